// File: rtl/button_cmd_scheduler.sv
// Shared button front-end: one slow sample tick, per-button press/auto-repeat detection,
// and a round-robin arbiter that serialises the events onto one valid/ready command port.
module button_cmd_scheduler #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 250000,
   parameter int HOLD_TICKS   = 200,
   parameter int REPEAT_TICKS = 40,
   parameter int IDW          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clkDB,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [IDW-1:0]   cmd_id,
   output logic             cmd_repeat,
   output logic [N_BTN-1:0] btn_level,
   output logic             tick,
   output logic             drop_pulse
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);
   localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] RELOAD_V = HW'(HOLD_TICKS - REPEAT_TICKS);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} arb_state_t;

   logic [CW-1:0]    cnt;
   logic [N_BTN-1:0] s0, s1, s2;
   logic [HW-1:0]    hcnt [N_BTN];
   logic [N_BTN-1:0] press_ev, rep_ev, any_ev;
   logic [N_BTN-1:0] pend, rep;
   logic [N_BTN-1:0] grant_oh, drop_vec;
   logic [IDW-1:0]   last_grant, grant_idx;
   logic             grant_en, found;
   int               scan_idx;
   arb_state_t       state, state_next;

   // tick is registered, so it is set one count early to line up with cnt==TICK_DIV-1
   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) cnt <= '0;
         else                 cnt <= cnt + 1'b1;
         tick <= (cnt == CNT_PRE);
      end
   end

   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else if (tick) begin
         s0 <= btn_in;
         s1 <= s0;
         s2 <= s1;
      end
   end

   always_comb begin
      press_ev = '0;
      rep_ev   = '0;
      for (int i = 0; i < N_BTN; i++) begin
         press_ev[i] = tick & s1[i] & ~s2[i];
         rep_ev[i]   = tick & s1[i] & s2[i] & (hcnt[i] == HOLD_V);
      end
      any_ev = press_ev | rep_ev;
   end

   // hold counter saturates by reloading on each repeat, so it never exceeds HOLD_TICKS
   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BTN; i++) hcnt[i] <= '0;
      end else if (tick) begin
         for (int i = 0; i < N_BTN; i++) begin
            if (press_ev[i] || !s1[i]) hcnt[i] <= '0;
            else if (rep_ev[i])        hcnt[i] <= RELOAD_V;
            else if (s2[i])            hcnt[i] <= hcnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // round-robin search starts just after the last granted button
   always_comb begin
      state_next = state;
      grant_en   = 1'b0;
      grant_idx  = '0;
      found      = 1'b0;
      scan_idx   = 0;
      grant_oh   = '0;
      case (state)
         IDLE: begin
            if (|pend) begin
               for (int k = 1; k <= N_BTN; k++) begin
                  scan_idx = (int'(last_grant) + k) % N_BTN;
                  if (!found && pend[scan_idx]) begin
                     found     = 1'b1;
                     grant_idx = IDW'(scan_idx);
                  end
               end
               grant_en   = 1'b1;
               state_next = OFFER;
            end
         end
         OFFER: begin
            if (cmd_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (grant_en) grant_oh[grant_idx] = 1'b1;
      drop_vec = any_ev & pend & ~grant_oh;
   end

   // a new event overwrites only a slot that is free or being granted this very cycle
   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         rep        <= '0;
         drop_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (any_ev[i]) begin
               if (!drop_vec[i]) begin
                  pend[i] <= 1'b1;
                  rep[i]  <= rep_ev[i];
               end
            end else if (grant_oh[i]) begin
               pend[i] <= 1'b0;
            end
         end
         drop_pulse <= |drop_vec;
      end
   end

   always_ff @(posedge clkDB or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid  <= 1'b0;
         cmd_id     <= '0;
         cmd_repeat <= 1'b0;
         last_grant <= IDW'(N_BTN - 1);
      end else if (grant_en) begin
         cmd_valid  <= 1'b1;
         cmd_id     <= grant_idx;
         cmd_repeat <= rep[grant_idx];
         last_grant <= grant_idx;
      end else if (state == OFFER && cmd_ready) begin
         cmd_valid  <= 1'b0;
      end
   end

   assign btn_level = s1 & s2;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Bench for button_cmd_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_button_cmd_scheduler;

   localparam int N   = 4;
   localparam int TD  = 4;
   localparam int HT  = 6;
   localparam int RT  = 2;
   localparam int IDW = 2;

   logic           clkDB = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   btn_in = '0;
   logic           cmd_ready = 1'b1;
   logic           cmd_valid;
   logic [IDW-1:0] cmd_id;
   logic           cmd_repeat;
   logic [N-1:0]   btn_level;
   logic           tick;
   logic           drop_pulse;

   int total = 0;
   int bad   = 0;

   int hs_q[$];
   int drop_cnt  = 0;
   int valid_cnt = 0;

   bit m_s0 [N];
   bit m_s1 [N];
   bit m_s2 [N];
   int m_held [N];
   bit m_pend [N];
   bit m_rep  [N];
   int m_cyc, m_last, m_id;
   bit m_tick, m_busy, m_crep, m_drop;

   button_cmd_scheduler #(
      .N_BTN(N), .TICK_DIV(TD), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
   ) dut (
      .clkDB(clkDB), .rst_n(rst_n), .btn_in(btn_in), .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_repeat(cmd_repeat),
      .btn_level(btn_level), .tick(tick), .drop_pulse(drop_pulse)
   );

   always #5 clkDB = ~clkDB;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: repeats come from the number of held ticks since the press, not a counter copy
   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         m_s0[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
         m_held[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
      end
      m_cyc = 0; m_tick = 0; m_last = N - 1; m_busy = 0; m_id = 0; m_crep = 0; m_drop = 0;
   endtask

   task automatic modelStep();
      bit tk;
      bit ev [N];
      bit isrep [N];
      int g;
      bit grep;
      bit drop;
      tk = ((m_cyc % TD) == TD - 1);
      for (int i = 0; i < N; i++) begin
         ev[i] = 0; isrep[i] = 0;
         if (tk) begin
            if (m_s1[i] && !m_s2[i]) begin
               ev[i] = 1; m_held[i] = 0;
            end else if (m_s1[i] && m_s2[i]) begin
               m_held[i]++;
               if (m_held[i] >= HT + 1 && ((m_held[i] - HT - 1) % (RT + 1)) == 0) begin
                  ev[i] = 1; isrep[i] = 1;
               end
            end else begin
               m_held[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = m_s0[i];
            m_s0[i] = btn_in[i];
         end
      end
      g = -1;
      if (!m_busy) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (g < 0 && m_pend[j]) g = j;
         end
      end
      grep = (g >= 0) ? m_rep[g] : 1'b0;
      drop = 0;
      for (int i = 0; i < N; i++) begin
         if (ev[i]) begin
            if (m_pend[i] && i != g) drop = 1;
            else begin m_pend[i] = 1; m_rep[i] = isrep[i]; end
         end else if (i == g) begin
            m_pend[i] = 0;
         end
      end
      if (m_busy) begin
         if (cmd_ready) m_busy = 0;
      end else if (g >= 0) begin
         m_busy = 1; m_id = g; m_crep = grep; m_last = g;
      end
      m_drop = drop;
      m_cyc++;
      m_tick = ((m_cyc % TD) == TD - 1);
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge clkDB or negedge rst_n);
         if (!rst_n) modelReset();
         else        modelStep();
      end
   end

   // every-cycle comparison against the model
   initial begin
      forever begin
         logic [N-1:0] lv;
         @(negedge clkDB);
         for (int i = 0; i < N; i++) lv[i] = m_s1[i] & m_s2[i];
         checkOutput("tick", tick, m_tick);
         checkOutput("cmd_valid", cmd_valid, m_busy);
         if (m_busy) begin
            checkOutput("cmd_id", cmd_id, m_id);
            checkOutput("cmd_repeat", cmd_repeat, m_crep);
         end
         checkOutput("drop_pulse", drop_pulse, m_drop);
         checkOutput("btn_level", btn_level, lv);
      end
   end

   // handshake / pulse recorder for the directed literal checks
   initial begin
      forever begin
         @(negedge clkDB);
         #2;
         if (cmd_valid && cmd_ready) hs_q.push_back(int'(cmd_id) * 2 + int'(cmd_repeat));
         if (drop_pulse) drop_cnt++;
         if (cmd_valid) valid_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int qAt(input int i);
      if (i < hs_q.size()) return hs_q[i];
      return -1;
   endfunction

   task automatic applyStimulus(input logic [N-1:0] b, input logic r);
      btn_in    = b;
      cmd_ready = r;
   endtask

   task automatic applyReset();
      @(negedge clkDB);
      #1;
      rst_n = 1'b0;
      applyStimulus('0, 1'b1);
      repeat (3) @(negedge clkDB);
      #1;
      rst_n = 1'b1;
      hs_q.delete();
      drop_cnt  = 0;
      valid_cnt = 0;
   endtask

   // returns at the negedge of a tick cycle, or records a failure after the bound
   task automatic waitTick();
      bit seen;
      seen = 0;
      for (int c = 0; c < 3 * TD && !seen; c++) begin
         @(negedge clkDB);
         if (tick) seen = 1;
      end
      if (!seen) checkOutput("tick_wait", 0, 1);
   endtask

   initial begin
      int first;
      int tcount;

      // idle after reset: tick cadence, no commands or drops
      applyReset();
      checkOutput("reset_valid", cmd_valid, 0);
      checkOutput("reset_tick", tick, 0);
      first = -1; tcount = 0;
      for (int m = 1; m <= 40; m++) begin
         @(negedge clkDB);
         if (tick) begin
            tcount++;
            if (first < 0) first = m;
         end
      end
      checkOutput("idle_tick_count", tcount, 10);
      checkOutput("idle_first_tick", first, 3);
      checkOutput("idle_valid_cnt", valid_cnt, 0);
      checkOutput("idle_drop_cnt", drop_cnt, 0);

      // single short press on button 2
      applyReset();
      waitTick();
      #1 applyStimulus(4'b0100, 1'b1);
      first = -1;
      for (int m = 1; m <= 40; m++) begin
         @(negedge clkDB);
         if (cmd_valid && first < 0) first = m;
         if (m == 16) #1 applyStimulus(4'b0000, 1'b1);
      end
      checkOutput("press_latency", first, 10);
      checkOutput("press_count", hs_q.size(), 1);
      checkOutput("press_cmd", qAt(0), 4);

      // long hold on button 1: press then three repeats
      applyReset();
      waitTick();
      #1 applyStimulus(4'b0010, 1'b1);
      for (int m = 1; m <= 80; m++) begin
         @(negedge clkDB);
         if (m == 20) checkOutput("hold_level", btn_level, 4'b0010);
         if (m == 54) #1 applyStimulus(4'b0000, 1'b1);
      end
      checkOutput("hold_count", hs_q.size(), 4);
      checkOutput("hold_cmd0", qAt(0), 2);
      checkOutput("hold_cmd1", qAt(1), 3);
      checkOutput("hold_cmd3", qAt(3), 3);

      // simultaneous presses on buttons 0 and 3
      applyReset();
      waitTick();
      #1 applyStimulus(4'b1001, 1'b1);
      repeat (30) @(negedge clkDB);
      checkOutput("rr_count", hs_q.size(), 2);
      checkOutput("rr_first", qAt(0), 0);
      checkOutput("rr_second", qAt(1), 6);

      // stalled consumer: held command, one drop, then queued repeat
      applyReset();
      waitTick();
      #1 applyStimulus(4'b0010, 1'b0);
      for (int m = 1; m <= 70; m++) begin
         @(negedge clkDB);
         if (m == 20 || m == 45) begin
            checkOutput("stall_valid", cmd_valid, 1);
            checkOutput("stall_id", cmd_id, 1);
            checkOutput("stall_repeat", cmd_repeat, 0);
         end
         if (m == 49) checkOutput("stall_drop", drop_pulse, 1);
         if (m == 50) #1 applyStimulus(4'b0010, 1'b1);
         if (m == 54) #1 applyStimulus(4'b0000, 1'b1);
      end
      checkOutput("stall_drop_cnt", drop_cnt, 1);
      checkOutput("stall_count", hs_q.size(), 3);
      checkOutput("stall_cmd0", qAt(0), 2);
      checkOutput("stall_cmd1", qAt(1), 3);

      // reset in the middle of an offer
      applyReset();
      waitTick();
      #1 applyStimulus(4'b0100, 1'b0);
      repeat (12) @(negedge clkDB);
      checkOutput("offer_before_reset", cmd_valid, 1);
      #1;
      rst_n = 1'b0;
      applyStimulus('0, 1'b0);
      #1 checkOutput("reset_async_clear", cmd_valid, 0);
      repeat (3) @(negedge clkDB);
      #1;
      rst_n = 1'b1;
      applyStimulus('0, 1'b1);
      valid_cnt = 0;
      hs_q.delete();
      repeat (40) @(negedge clkDB);
      checkOutput("no_stale_cmd", valid_cnt, 0);

      // randomized buttons and consumer back-pressure
      applyReset();
      begin
         bit stall_mode;
         stall_mode = 0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge clkDB);
            #1;
            if ((c % 200) == 0) stall_mode = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) begin
               int b;
               b = $urandom_range(0, N - 1);
               btn_in[b] = ~btn_in[b];
            end
            if (stall_mode) cmd_ready = ($urandom_range(0, 9) == 0);
            else            cmd_ready = ($urandom_range(0, 3) != 0);
            if (c == 2000) rst_n = 1'b0;
            if (c == 2003) rst_n = 1'b1;
         end
      end

      repeat (2) @(negedge clkDB);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
